// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle stage FSM issuing IR/PC/RB/MEM write strobes.
// Define SEQ_WATCHDOG_EN to add an INSW timeout with a sticky io_timeout flag.

module cycle_sequencer #(
    parameter int RESET_CYCLES    = 4,
    parameter int MEM_WAIT        = 1,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] ID,
    input  logic [1:0] controlEM,
    input  logic [2:0] controlRB,
    input  logic       button,
    output logic       ir_load,
    output logic       pc_write,
    output logic       rb_write,
    output logic       mem_write,
    output logic [2:0] stage,
    output logic       MODE,
    output logic       wait_io,
    output logic       halted,
    output logic       io_timeout
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_WAITIO = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [6:0] ID_INSW = 7'd71;
    localparam logic [6:0] ID_SWI  = 7'd72;
    localparam logic [6:0] ID_HALT = 7'd75;

    localparam int MAX_A = (RESET_CYCLES > MEM_WAIT) ? RESET_CYCLES : MEM_WAIT;
`ifdef SEQ_WATCHDOG_EN
    localparam int MAX_C = (MAX_A > WATCHDOG_CYCLES) ? MAX_A : WATCHDOG_CYCLES;
`else
    localparam int MAX_C = MAX_A;
`endif
    localparam int CW = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT);
`ifdef SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST  = CW'(WATCHDOG_CYCLES - 1);
`endif

    if (RESET_CYCLES < 1 || MEM_WAIT < 0 || WATCHDOG_CYCLES < 1) begin : g_bad_cfg
        $error("cycle_sequencer: invalid parameter value");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          button_prev_q, button_prev_d;
    logic          btn_edge;
`ifdef SEQ_WATCHDOG_EN
    logic          tmo_q, tmo_d;
    logic          wd_fire_q, wd_fire_d;
`endif

    assign btn_edge = button & ~button_prev_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        button_prev_d = button;
`ifdef SEQ_WATCHDOG_EN
        tmo_d         = tmo_q;
        wd_fire_d     = wd_fire_q;
`endif
        unique case (state_q)
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (ID == ID_HALT) begin
                    state_d = S_HALT;
                end else if (ID == ID_INSW) begin
                    state_d = S_WAITIO;
                    cnt_d   = '0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (controlEM != 2'd0 || controlRB == 3'd3) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q == MEM_LAST) begin
                    state_d = S_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                if (ID == ID_SWI) mode_d = ~mode_q;
`ifdef SEQ_WATCHDOG_EN
                wd_fire_d = 1'b0;
`endif
            end
            S_WAITIO: begin
                // A button edge beats a timeout landing in the same cycle.
                if (btn_edge) begin
                    state_d = S_WB;
`ifdef SEQ_WATCHDOG_EN
                end else if (cnt_q == WD_LAST) begin
                    state_d   = S_WB;
                    tmo_d     = 1'b1;
                    wd_fire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            S_HALT: begin
                if (btn_edge) state_d = S_WB;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        ir_load   = (state_q == S_FETCH);
        pc_write  = (state_q == S_WB);
        mem_write = (state_q == S_MEM) && (cnt_q == '0) && (controlEM != 2'd0);
`ifdef SEQ_WATCHDOG_EN
        rb_write  = (state_q == S_WB) && (controlRB != 3'd0) && !wd_fire_q;
        io_timeout = tmo_q;
`else
        rb_write  = (state_q == S_WB) && (controlRB != 3'd0);
        io_timeout = 1'b0;
`endif
        stage     = state_q;
        MODE      = mode_q;
        wait_io   = (state_q == S_WAITIO);
        halted    = (state_q == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_RESET;
            cnt_q         <= '0;
            mode_q        <= 1'b1;
            button_prev_q <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
            tmo_q         <= 1'b0;
            wd_fire_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            button_prev_q <= button_prev_d;
`ifdef SEQ_WATCHDOG_EN
            tmo_q         <= tmo_d;
            wd_fire_q     <= wd_fire_d;
`endif
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: random instruction stream against a per-instruction
// timing/strobe model; a negedge monitor pops expectations at each pc_write.

module tb_cycle_sequencer;

    localparam int RC = 4;
    localparam int MW = 1;
    localparam int WD = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] ID = '0;
    logic [1:0] controlEM = '0;
    logic [2:0] controlRB = '0;
    logic       button = 1'b1;
    logic       ir_load, pc_write, rb_write, mem_write;
    logic [2:0] stage;
    logic       MODE, wait_io, halted, io_timeout;

    cycle_sequencer #(
        .RESET_CYCLES(RC),
        .MEM_WAIT(MW),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ID(ID),
        .controlEM(controlEM),
        .controlRB(controlRB),
        .button(button),
        .ir_load(ir_load),
        .pc_write(pc_write),
        .rb_write(rb_write),
        .mem_write(mem_write),
        .stage(stage),
        .MODE(MODE),
        .wait_io(wait_io),
        .halted(halted),
        .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int lat;
        int mem_n;
        int rb_n;
        int halt_n;
        int wait_n;
        bit mode;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   mode_m = 1'b1;
    bit   tmo_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ir();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (ir_load) seen = 1'b1;
        end
        chk("fetch_seen", int'(seen), 1);
    endtask

    // k: cycles the button stays high in the stall state before the
    // low/high pulse; k < 0 means no pulse at all (watchdog path).
    task automatic issue(input int id, input int em, input int rb, input int k);
        bit   stall, tmo, memi;
        exp_t e;
        wait_ir();
        @(posedge clock); #1;
        ID        = 7'(id);
        controlEM = 2'(em);
        controlRB = 3'(rb);
        button    = 1'b1;
        stall = (id == 71) || (id == 75);
        tmo   = (id == 71) && (k < 0);
        memi  = !stall && (em != 0 || rb == 3);
        e.lat    = tmo ? 2 + WD : stall ? 4 + k : memi ? 4 + MW : 3;
        e.mem_n  = (memi && em != 0) ? 1 : 0;
        e.rb_n   = (rb != 0 && !tmo) ? 1 : 0;
        e.halt_n = (id == 75) ? k + 2 : 0;
        e.wait_n = (id == 71) ? (tmo ? WD : k + 2) : 0;
        if (id == 72) mode_m = !mode_m;
        if (tmo) tmo_m = 1'b1;
        e.mode = mode_m;
        e.tmo  = tmo_m;
        exp_q.push_back(e);
        if (stall && !tmo) begin
            for (int t = 2; t <= 3 + k; t++) begin
                @(posedge clock); #1;
                button = (t == 2 + k) ? 1'b0 : 1'b1;
            end
        end
    endtask

    int   cyc = 0, start_c = 0, last_pc = 0;
    int   mem_c = 0, rb_c = 0, halt_c = 0, wait_c = 0;
    bit   inflight = 1'b0, chk_pend = 1'b0;
    exp_t rec, pend;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                inflight = 1'b0;
                chk_pend = 1'b0;
            end else begin
                if (ir_load) begin
                    chk("fetch_stage", int'(stage), 1);
                    chk("orphan_fetch", int'(inflight), 0);
                    if (chk_pend) begin
                        chk("fetch_gap", cyc - last_pc, 1);
                        chk("mode", int'(MODE), int'(pend.mode));
                        chk("io_timeout", int'(io_timeout), int'(pend.tmo));
                        chk_pend = 1'b0;
                    end
                    inflight = 1'b1;
                    start_c  = cyc;
                    mem_c = 0; rb_c = 0; halt_c = 0; wait_c = 0;
                end
                if (inflight) begin
                    mem_c  += int'(mem_write);
                    rb_c   += int'(rb_write);
                    halt_c += int'(halted);
                    wait_c += int'(wait_io);
                end
                if (pc_write) begin
                    chk("pc_write_expected", exp_q.size() > 0 ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        rec = exp_q.pop_front();
                        chk("wb_latency", cyc - start_c, rec.lat);
                        chk("wb_stage", int'(stage), 5);
                        chk("rb_write", rb_c, rec.rb_n);
                        chk("mem_write", mem_c, rec.mem_n);
                        chk("halted_cycles", halt_c, rec.halt_n);
                        chk("wait_io_cycles", wait_c, rec.wait_n);
                        pend = rec;
                    end
                    inflight = 1'b0;
                    chk_pend = 1'b1;
                    last_pc  = cyc;
                end
            end
            cyc++;
        end
    end

    initial begin
        int kind, id;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < RC; i++) begin
            @(negedge clock);
            chk("reset_stage", int'(stage), 0);
            chk("reset_strobes", int'({ir_load, pc_write, rb_write, mem_write}), 0);
        end
        chk("reset_mode", int'(MODE), 1);
        chk("reset_io_timeout", int'(io_timeout), 0);
        chk("reset_wait_halt", int'({wait_io, halted}), 0);

        issue(4, 0, 1, 0);
        issue(40, 3, 0, 0);
        issue(71, 0, 1, 3);
        issue(72, 0, 0, 0);
        issue(72, 0, 0, 0);
        issue(75, 0, 0, 50);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            id   = int'($urandom_range(0, 70));
            case (kind)
                0, 1, 2: issue(id, 0, int'($urandom_range(0, 2)), 0);
                3:       issue(id, 0, int'($urandom_range(4, 7)), 0);
                4:       issue(id, 0, 3, 0);
                5, 6:    issue(id, int'($urandom_range(1, 3)), 0, 0);
                7:       issue(72, 0, 0, 0);
                8:       issue(71, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
                default: issue(75, 0, 0, int'($urandom_range(0, 10)));
            endcase
        end

        if (mode_m) issue(72, 0, 0, 0);
        wait_ir();
        @(posedge clock); #1;
        ID = 7'd40; controlEM = 2'd3; controlRB = 3'd0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("mem_first_stage", int'(stage), 4);
        chk("mem_first_write", int'(mem_write), 1);
        @(posedge clock); #1;
        chk("mem_second_stage", int'(stage), 4);
        chk("mem_second_write", int'(mem_write), 0);
        reset = 1'b1;
        exp_q.delete();
        mode_m = 1'b1;
        tmo_m  = 1'b0;
        @(posedge clock); #1;
        chk("midreset_stage", int'(stage), 0);
        chk("midreset_mode", int'(MODE), int'(mode_m));
        chk("midreset_strobes", int'({ir_load, pc_write, rb_write, mem_write}), 0);
        reset = 1'b0;

        issue(4, 0, 1, 0);
        issue(72, 0, 0, 0);
`ifdef SEQ_WATCHDOG_EN
        issue(71, 0, 2, -1);
        issue(4, 0, 1, 0);
        issue(71, 0, 1, 6);
        issue(71, 0, 3, -1);
        issue(5, 0, 2, 0);
`endif
        wait_ir();
        repeat (2) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
